// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one imem transaction open at a time,
// buffers a response across IF/ID stalls and squashes responses made stale by a redirect.
module fetch_stage #(
  parameter int            AW       = 32,
  parameter int            IW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Stall,
  input  logic          Redirect,
  input  logic [AW-1:0] RedirectPC,
  output logic          ImemReq,
  output logic [AW-1:0] ImemAddr,
  input  logic          ImemReady,
  input  logic [IW-1:0] ImemRdata,
  output logic          FetchEn,
  output logic          FetchValid,
  output logic [IW-1:0] FetchInstr,
  output logic [AW-1:0] FetchPC
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t        r_state, w_nstate;
  logic [AW-1:0] r_pc, w_npc;
  logic [AW-1:0] r_pend, w_npend;
  logic [IW-1:0] r_buf, w_nbuf;
  logic [AW-1:0] w_rpc, w_pc_inc;

  assign w_rpc    = RedirectPC & ~AW'(3);
  assign w_pc_inc = r_pc + AW'(4);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_pend  <= '0;
      r_buf   <= '0;
    end else begin
      r_state <= w_nstate;
      r_pc    <= w_npc;
      r_pend  <= w_npend;
      r_buf   <= w_nbuf;
    end
  end

  always_comb begin
    w_nstate   = r_state;
    w_npc      = r_pc;
    w_npend    = r_pend;
    w_nbuf     = r_buf;
    ImemReq    = 1'b0;
    ImemAddr   = '0;
    FetchEn    = 1'b0;
    FetchValid = 1'b0;
    FetchInstr = '0;
    FetchPC    = '0;
    if (!Rst) begin
      unique case (r_state)
        S_IDLE: begin
          w_nstate = S_WAIT;
          if (Redirect) begin
            FetchEn = 1'b1;
            w_npc   = w_rpc;
          end
        end
        S_WAIT: begin
          ImemReq  = 1'b1;
          ImemAddr = r_pc;
          if (ImemReady) begin
            if (Redirect) begin
              FetchEn = 1'b1;
              w_npc   = w_rpc;
            end else if (!Stall) begin
              FetchEn    = 1'b1;
              FetchValid = 1'b1;
              FetchInstr = ImemRdata;
              FetchPC    = r_pc;
              w_npc      = w_pc_inc;
            end else begin
              w_nbuf   = ImemRdata;
              w_nstate = S_HOLD;
            end
          end else if (Redirect) begin
            // The open request can't be withdrawn; remember the target and squash its reply.
            FetchEn  = 1'b1;
            w_npend  = w_rpc;
            w_nstate = S_DROP;
          end
        end
        S_HOLD: begin
          if (Redirect) begin
            FetchEn  = 1'b1;
            w_npc    = w_rpc;
            w_nstate = S_WAIT;
          end else if (!Stall) begin
            FetchEn    = 1'b1;
            FetchValid = 1'b1;
            FetchInstr = r_buf;
            FetchPC    = r_pc;
            w_npc      = w_pc_inc;
            w_nstate   = S_WAIT;
          end
        end
        S_DROP: begin
          ImemReq  = 1'b1;
          ImemAddr = r_pc;
          if (Redirect) begin
            FetchEn = 1'b1;
            w_npend = w_rpc;
          end
          if (ImemReady) begin
            w_npc    = Redirect ? w_rpc : r_pend;
            w_nstate = S_WAIT;
          end
        end
        default: w_nstate = S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the PC and issues one-outstanding requests to instruction memory. It delivers fetched instruction/PC/valid to the IF/ID register's Din, together with that register's enable. It absorbs hazard-unit stalls by buffering a returned instruction, and handles branch redirects by writing a bubble and discarding in-flight responses.

## Interface
- AW, 32, PC / instruction-address width
- IW, 32, instruction width
- RESET_PC, 0, PC value after reset; low 2 bits must be 0
- Clk  input  1  clock
- Rst  input  1  reset, synchronous, active-high
- Stall  input  1  hazard unit: IF/ID must hold
- Redirect  input  1  branch/jump taken; flush IF/ID and refetch
- RedirectPC  input  AW  target PC; bits [1:0] ignored (forced 0)
- ImemReq  output  1  request valid (level)
- ImemAddr  output  AW  request address; stable while ImemReq high and transaction open
- ImemReady  input  1  response valid; transaction completes on cycle with ImemReq & ImemReady
- ImemRdata  input  IW  response data, valid with ImemReady
- FetchEn  output  1  drives IF/ID En
- FetchValid  output  1  IF/ID Din valid bit (0 = bubble)
- FetchInstr  output  IW  IF/ID Din instruction
- FetchPC  output  AW  IF/ID Din PC

## Operation
- Registers: PC, PendPC, InstrBuf, 2-bit state. Fetch outputs combinational from state/inputs; IF/ID registers them.
- Rst high: state<=IDLE, PC<=RESET_PC, PendPC<=0, InstrBuf<=0; all outputs 0 that cycle. Rst beats everything; any outstanding memory response is dropped (memory shares Rst).
- IDLE: ImemReq=0, FetchEn=0; next state WAIT unconditionally (Redirect in IDLE: PC<=RedirectPC, FetchEn=1, FetchValid=0).
- WAIT: ImemReq=1, ImemAddr=PC.
  - Ready & Redirect: FetchEn=1, FetchValid=0; PC<=RedirectPC; stay WAIT.
  - Ready & !Stall: FetchEn=1, FetchValid=1, FetchInstr=ImemRdata, FetchPC=PC; PC<=PC+4; stay WAIT.
  - Ready & Stall: InstrBuf<=ImemRdata; FetchEn=0; -> HOLD.
  - !Ready & Redirect: FetchEn=1, FetchValid=0; PendPC<=RedirectPC; -> DROP.
  - !Ready otherwise: FetchEn=0; stay.
- HOLD: ImemReq=0.
  - Redirect: FetchEn=1, FetchValid=0; PC<=RedirectPC; -> WAIT.
  - !Stall: FetchEn=1, FetchValid=1, FetchInstr=InstrBuf, FetchPC=PC; PC<=PC+4; -> WAIT.
  - Stall: FetchEn=0; stay.
- DROP: ImemReq=1, ImemAddr=PC (old address, kept stable).
  - Redirect: FetchEn=1, FetchValid=0; PendPC<=RedirectPC (latest wins).
  - Ready: response discarded; PC<=Redirect ? RedirectPC : PendPC; -> WAIT.
- Priority everywhere: Rst > Redirect > Stall.
- Arithmetic: PC+4 modulo 2^AW (0xFFFFFFFC -> 0x00000000 at AW=32). No overflow flag.
- When FetchEn=0, FetchValid/FetchInstr/FetchPC are 0.

## Timing
- Cycle 0 = first cycle with Rst low: IDLE. Cycle 1: first request, addr RESET_PC.
- Zero-wait memory (Ready same cycle as Req): one instruction per cycle, IF/ID loaded at end of cycle 1.
- N-wait memory: one instruction per N+1 cycles; no request gap between transactions.
- Redirect to first valid fetch of target: 1 cycle (from WAIT/HOLD with Ready or HOLD); from DROP, waits for the stale response first.
- At most one outstanding transaction; ImemAddr never changes inside an open transaction.
- Stall never loses a returned instruction; HOLD releases it in the first cycle Stall drops.

## Test plan
- Reset, zero-wait memory, Stall=0: ImemAddr 0,4,8,12 on cycles 1-4; FetchEn=1, FetchValid=1, FetchPC matches each cycle.
- 2-wait memory, Stall high for 3 cycles spanning Ready on instr at 0x8: ImemReq low in HOLD; 0x8 delivered exactly once, first cycle after Stall falls; next request 0xC.
- Redirect to 0x100 while request to 0x10 pending: bubble (FetchEn=1, FetchValid=0) that cycle; ImemAddr stays 0x10 until Ready; 0x10 data never delivered; next request 0x100.
- Two Redirects (0x200 then 0x300) during DROP: refetch from 0x300 only; Redirect coinciding with Stall writes bubble.
- RESET_PC=0xFFFFFFF8, zero-wait: addresses FFFFFFF8, FFFFFFFC, 00000000.
- Rst asserted mid-DROP with Ready same cycle: all outputs 0; after release fetch restarts at RESET_PC, stale data discarded.
